fdu_heartbeat_gen: RTL

//  Upstream partner of the FDU watchdog: drives the 3-bit Gray-coded heartbeat fdu[2:0]
//  (000,001,011,010,110,111,101,100,000...) that the watchdog checks.
//  The code advances one step per software kick, and each code is held for at least MIN_HOLD cycles.
//  A missing kick freezes the code and flags a stall; a skip-injection input exercises the watchdog's ERROR path.

---
 rtl/fdu_heartbeat_gen.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/fdu_heartbeat_gen.sv
// -----------------------------------------------------------------------------
// fdu_heartbeat_gen
//   Upstream partner of the FDU watchdog. Drives a 3-bit Gray-coded heartbeat
//   (000,001,011,010,110,111,101,100,000,...) that advances one step per
//   software kick, with every code held for at least MIN_HOLD cycles. A
//   missing kick freezes the code and raises 'stalled'; 'inject_skip' makes an
//   advance jump two positions so the watchdog's error path can be exercised.
//
// Ports
//   clk          in   1   system clock, all logic on posedge
//   reset        in   1   asynchronous, active-low reset
//   enable       in   1   level; 0 returns to IDLE with fdu=000
//   kick         in   1   1-cycle request to advance the heartbeat
//   inject_skip  in   1   level; sampled at advance, 1 = advance by two
//   fdu          out  3   registered Gray-coded heartbeat
//   stalled      out  1   1 while in STALL
//   overrun      out  1   sticky: a kick was dropped (second pending kick)
//   cycle_done   out  1   1-cycle pulse when the index wraps past 7
//   wrap_count   out 16   number of wraps, modulo 2^16
// -----------------------------------------------------------------------------
module fdu_heartbeat_gen #(
  parameter int unsigned MIN_HOLD     = 8,        // >= 2
  parameter int unsigned KICK_TIMEOUT = 6000000,  // > MIN_HOLD + 1
  parameter int unsigned CNT_W        = 24        // must hold KICK_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        kick,
  input  logic        inject_skip,
  output logic [2:0]  fdu,
  output logic        stalled,
  output logic        overrun,
  output logic        cycle_done,
  output logic [15:0] wrap_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HOLD  = 2'd1,
    S_READY = 2'd2,
    S_STALL = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MIN_HOLD - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(KICK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           r_state;
  logic [2:0]       r_idx;
  logic [2:0]       r_fdu;
  logic             r_pend;
  logic             r_stalled;
  logic             r_overrun;
  logic             r_cycle_done;
  logic [15:0]      r_wrap_count;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [CNT_W-1:0] r_to_cnt;

  // Next index and its Gray code. Bit 3 of the sum marks a wrap past 7.
  logic [3:0] w_sum;
  logic [2:0] w_next_idx;
  logic [2:0] w_next_gray;
  logic       w_advance;

  assign w_sum       = {1'b0, r_idx} + (inject_skip ? 4'd2 : 4'd1);
  assign w_next_idx  = w_sum[2:0];
  assign w_next_gray = w_next_idx ^ (w_next_idx >> 1);
  // A pending kick fires on the first READY cycle, same as a live kick.
  assign w_advance   = (r_state == S_READY) && (kick || r_pend);

  // NOTE: every register, including the counters, is cleared by the async
  // reset so the outputs are defined before the first clock edge; all state
  // updates use non-blocking assignments so the whole block reads the values
  // from before the edge regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_idx        <= 3'd0;
      r_fdu        <= 3'd0;
      r_pend       <= 1'b0;
      r_stalled    <= 1'b0;
      r_overrun    <= 1'b0;
      r_cycle_done <= 1'b0;
      r_wrap_count <= 16'd0;
      r_hold_cnt   <= '0;
      r_to_cnt     <= '0;
    end else begin
      r_cycle_done <= 1'b0;
      if (!enable) begin
        // Disable overrides everything, including a kick in the same cycle.
        // overrun and wrap_count are deliberately kept.
        r_state    <= S_IDLE;
        r_idx      <= 3'd0;
        r_fdu      <= 3'd0;
        r_pend     <= 1'b0;
        r_stalled  <= 1'b0;
        r_hold_cnt <= '0;
        r_to_cnt   <= '0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            r_state    <= S_HOLD;
            r_hold_cnt <= '0;
            r_to_cnt   <= '0;
          end

          S_HOLD: begin
            if (kick) begin
              if (r_pend) r_overrun <= 1'b1;
              else        r_pend    <= 1'b1;
            end
            if (r_to_cnt == TO_LAST) begin
              r_state   <= S_STALL;
              r_stalled <= 1'b1;
            end else begin
              r_to_cnt <= r_to_cnt + CNT_ONE;
              if (r_hold_cnt == HOLD_LAST) begin
                r_state    <= S_READY;
                r_hold_cnt <= '0;
              end else begin
                r_hold_cnt <= r_hold_cnt + CNT_ONE;
              end
            end
          end

          S_READY: begin
            if (w_advance) begin
              // Advance wins over a timeout landing in the same cycle.
              r_idx      <= w_next_idx;
              r_fdu      <= w_next_gray;
              r_pend     <= 1'b0;
              r_to_cnt   <= '0;
              r_hold_cnt <= '0;
              r_state    <= S_HOLD;
              if (w_sum[3]) begin
                r_cycle_done <= 1'b1;
                r_wrap_count <= r_wrap_count + 16'd1;
              end
            end else if (r_to_cnt == TO_LAST) begin
              r_state   <= S_STALL;
              r_stalled <= 1'b1;
            end else begin
              r_to_cnt <= r_to_cnt + CNT_ONE;
            end
          end

          S_STALL: begin
            // Restart from code 000, mirroring the watchdog's ERROR->ZERO
            // recovery. This is not counted as a wrap.
            if (kick) begin
              r_idx      <= 3'd0;
              r_fdu      <= 3'd0;
              r_stalled  <= 1'b0;
              r_pend     <= 1'b0;
              r_hold_cnt <= '0;
              r_to_cnt   <= '0;
              r_state    <= S_HOLD;
            end
          end

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign fdu        = r_fdu;
  assign stalled    = r_stalled;
  assign overrun    = r_overrun;
  assign cycle_done = r_cycle_done;
  assign wrap_count = r_wrap_count;

endmodule
